// File: rtl/fir_tap_cfg_ctrl_pkg.sv
// Shared definitions for the runtime-programmable FIR coefficient path.
// The filter datapath uses the same default tap geometry.
package fir_cfg_pkg;

  localparam int TAP_WIDTH_DEF = 32;
  localparam int TAP_COUNT_DEF = 51;
  localparam int GEN_WIDTH     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/fir_tap_bank.sv
// Shadow/active coefficient register pair. The host writes the shadow bank.
// An apply strobe copies every shadow tap into the active bank on the same edge.
module fir_tap_bank
  import fir_cfg_pkg::*;
#(
  parameter  int TAP_WIDTH  = TAP_WIDTH_DEF,
  parameter  int TAP_COUNT  = TAP_COUNT_DEF,
  localparam int ADDR_WIDTH = $clog2(TAP_COUNT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [TAP_WIDTH-1:0]           data,
  input  logic                           apply,
  output logic [TAP_COUNT*TAP_WIDTH-1:0] taps_active
);

  for (genvar i = 0; i < TAP_COUNT; i++) begin : g_tap
    logic [TAP_WIDTH-1:0] shadow_q;
    logic [TAP_WIDTH-1:0] active_q;

    // NOTE: both banks are reset on purpose so the filter sees all-zero taps
    // until the first commit; a reset mid-update must also discard shadow writes.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        if (we && addr == ADDR_WIDTH'(i)) shadow_q <= data;
        if (apply)                        active_q <= shadow_q;
      end
    end

    assign taps_active[i*TAP_WIDTH +: TAP_WIDTH] = active_q;
  end

endmodule

// File: rtl/fir_tap_cfg_ctrl.sv
// Host-side coefficient configuration controller: accepts tap writes into a
// shadow bank and swaps them into the active bank only on a sample boundary.
module fir_tap_cfg_ctrl
  import fir_cfg_pkg::*;
#(
  parameter  int TAP_WIDTH  = TAP_WIDTH_DEF,
  parameter  int TAP_COUNT  = TAP_COUNT_DEF,
  localparam int ADDR_WIDTH = $clog2(TAP_COUNT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [ADDR_WIDTH-1:0]          cfg_addr,
  input  logic [TAP_WIDTH-1:0]           cfg_data,
  input  logic                           cfg_commit,
  input  logic                           sample_en,
  output logic [TAP_COUNT*TAP_WIDTH-1:0] taps_active,
  output logic                           taps_update,
  output logic [GEN_WIDTH-1:0]           tap_gen,
  output logic                           busy,
  output logic                           err_addr
);

  cfg_state_e state_q, state_d;
  logic       beat_acc;
  logic       addr_ok;
  logic       apply;

  assign beat_acc = cfg_valid && cfg_ready;
  assign addr_ok  = int'(cfg_addr) < TAP_COUNT;
  assign apply    = (state_q == PENDING) && sample_en;

  // NOTE: always_comb assigns every output a default first, so no path can
  // leave state_d unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat_acc) state_d = cfg_commit ? PENDING : LOAD;
      LOAD:    if (beat_acc && cfg_commit) state_d = PENDING;
      PENDING: if (sample_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cfg_ready and busy are registered from the next state so they change on
  // the same edge as the state itself and never follow cfg_valid.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      taps_update <= 1'b0;
      tap_gen     <= '0;
      err_addr    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready   <= (state_d != PENDING);
      busy        <= (state_d == PENDING);
      taps_update <= apply;
      if (apply) tap_gen <= tap_gen + GEN_WIDTH'(1);
      // Apply and acceptance are mutually exclusive (ready is low in PENDING).
      if (apply)                      err_addr <= 1'b0;
      else if (beat_acc && !addr_ok)  err_addr <= 1'b1;
    end
  end

  fir_tap_bank #(
    .TAP_WIDTH (TAP_WIDTH),
    .TAP_COUNT (TAP_COUNT)
  ) u_bank (
    .clk         (clk),
    .reset_n     (reset_n),
    .we          (beat_acc && addr_ok),
    .addr        (cfg_addr),
    .data        (cfg_data),
    .apply       (apply),
    .taps_active (taps_active)
  );

endmodule

// File: tb/tb_fir_tap_cfg_ctrl.sv
// Self-checking bench for fir_tap_cfg_ctrl: table-driven single-beat commits,
// hand-written multi-cycle sequences, and a scoreboard checking every apply.
module tb_fir_tap_cfg_ctrl;
  import fir_cfg_pkg::*;

  localparam int TW = 32;
  localparam int TC = 51;
  localparam int AW = $clog2(TC);

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [AW-1:0]     cfg_addr;
  logic [TW-1:0]     cfg_data;
  logic              cfg_commit;
  logic              sample_en;
  logic [TC*TW-1:0]  taps_active;
  logic              taps_update;
  logic [7:0]        tap_gen;
  logic              busy;
  logic              err_addr;

  fir_tap_cfg_ctrl #(.TAP_WIDTH(TW), .TAP_COUNT(TC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .sample_en   (sample_en),
    .taps_active (taps_active),
    .taps_update (taps_update),
    .tap_gen     (tap_gen),
    .busy        (busy),
    .err_addr    (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TC*TW-1:0] taps;
    logic [7:0]       gen;
  } sb_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic        exp_err;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  sb_t         sb_q[$];
  logic [31:0] model_sh [TC];
  logic [7:0]  exp_gen;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pulse_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tap(input int i);
    return taps_active[i*TW +: TW];
  endfunction

  function automatic logic [TC*TW-1:0] pack_model();
    logic [TC*TW-1:0] f;
    for (int i = 0; i < TC; i++) f[i*TW +: TW] = model_sh[i];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < TC; i++) model_sh[i] = '0;
    exp_gen = '0;
    sb_q.delete();
  endtask

  // Drives one beat and returns in the cycle after its acceptance edge.
  task automatic send_beat(input int a, input logic [31:0] d, input logic c);
    int guard;
    logic [5:0] a6;
    guard = 0;
    a6 = a[5:0];
    cfg_valid = 1'b1; cfg_addr = a6; cfg_data = d; cfg_commit = c;
    while (!cfg_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!cfg_ready) check("beat_ready_timeout", 64'(cfg_ready), 64'd1);
    step();
    if (a < TC) model_sh[a] = d;
    if (c) begin
      exp_gen = exp_gen + 8'd1;
      sb_q.push_back('{taps: pack_model(), gen: exp_gen});
    end
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  // Scoreboard: every taps_update pulse must match the oldest queued commit.
  initial begin
    sb_t e;
    int  idx;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && taps_update === 1'b1) begin
        pulse_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_update", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          idx = 0;
          for (int i = TC - 1; i >= 0; i--)
            if (taps_active[i*TW +: TW] !== e.taps[i*TW +: TW]) idx = i;
          check($sformatf("sb_tap[%0d]", idx), 64'(tap(idx)), 64'(e.taps[idx*TW +: TW]));
          check("sb_gen", 64'(tap_gen), 64'(e.gen));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   busy_cnt;
    int   p0;
    logic [7:0] g0;

    vecs[0] = '{addr: 10, data: 32'h7FFF_FFFF, exp_err: 1'b0, chk_idx: 10, chk_val: 32'h7FFF_FFFF};
    vecs[1] = '{addr: 60, data: 32'h0000_0123, exp_err: 1'b1, chk_idx: 10, chk_val: 32'h7FFF_FFFF};
    vecs[2] = '{addr: 0,  data: 32'hFFFF_FFFF, exp_err: 1'b0, chk_idx: 11, chk_val: 32'h0000_0008};
    vecs[3] = '{addr: 50, data: 32'h8000_0000, exp_err: 1'b0, chk_idx: 50, chk_val: 32'h8000_0000};

    reset_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_commit = 1'b0; sample_en = 1'b0;
    model_reset();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();

    // Reset state
    check("rst_ready", 64'(cfg_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_taps_any", 64'(|taps_active), 64'd0);
    check("rst_gen", 64'(tap_gen), 64'd0);
    check("rst_err", 64'(err_addr), 64'd0);
    check("rst_update", 64'(taps_update), 64'd0);

    // Full load, commit on the last tap, sample_en arrives 4 cycles later
    for (int i = 0; i < TC - 1; i++) send_beat(i, 32'(i * 3 - 25), 1'b0);
    check("load_ready", 64'(cfg_ready), 64'd1);
    send_beat(TC - 1, 32'((TC - 1) * 3 - 25), 1'b1);
    p0 = pulse_cnt;
    busy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy) busy_cnt++;
      if (k == 0) check("pend_ready", 64'(cfg_ready), 64'd0);
      if (k == 3) sample_en = 1'b1;
      step();
    end
    sample_en = 1'b0;
    check("full_busy_cycles", 64'(busy_cnt), 64'd4);
    check("full_busy_after", 64'(busy), 64'd0);
    check("full_ready_after", 64'(cfg_ready), 64'd1);
    check("full_update", 64'(taps_update), 64'd1);
    check("full_tap7", 64'(tap(7)), 64'(32'hFFFF_FFFC));
    check("full_gen", 64'(tap_gen), 64'd1);
    step();
    check("full_update_low", 64'(taps_update), 64'd0);
    check("full_pulses", 64'(pulse_cnt - p0), 64'd1);

    // Table: single-beat commits, partial updates and out-of-range address
    for (int v = 0; v < 4; v++) begin
      send_beat(vecs[v].addr, vecs[v].data, 1'b1);
      check($sformatf("vec%0d_err_accept", v), 64'(err_addr), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_busy", v), 64'(busy), 64'd1);
      sample_en = 1'b1;
      step();
      sample_en = 1'b0;
      check($sformatf("vec%0d_err_applied", v), 64'(err_addr), 64'd0);
      check($sformatf("vec%0d_gen", v), 64'(tap_gen), 64'(exp_gen));
      check($sformatf("vec%0d_tap", v), 64'(tap(vecs[v].chk_idx)), 64'(vecs[v].chk_val));
      step();
    end

    // Back-to-back commits with sample_en held high
    sample_en = 1'b1;
    g0 = tap_gen;
    p0 = pulse_cnt;
    send_beat(3, 32'h0000_0AAA, 1'b1);
    check("b2b_busy1", 64'(busy), 64'd1);
    step();
    check("b2b_update1", 64'(taps_update), 64'd1);
    check("b2b_ready1", 64'(cfg_ready), 64'd1);
    check("b2b_gen1", 64'(tap_gen), 64'(g0 + 8'd1));
    send_beat(4, 32'h0000_0BBB, 1'b1);
    check("b2b_update_gap", 64'(taps_update), 64'd0);
    check("b2b_busy2", 64'(busy), 64'd1);
    step();
    check("b2b_update2", 64'(taps_update), 64'd1);
    check("b2b_gen2", 64'(tap_gen), 64'(g0 + 8'd2));
    step();
    check("b2b_update_end", 64'(taps_update), 64'd0);
    check("b2b_pulses", 64'(pulse_cnt - p0), 64'd2);
    sample_en = 1'b0;

    // Asynchronous reset while a commit is pending
    send_beat(20, 32'h0000_0555, 1'b1);
    check("prst_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("prst_taps_any", 64'(|taps_active), 64'd0);
    check("prst_busy_low", 64'(busy), 64'd0);
    check("prst_gen", 64'(tap_gen), 64'd0);
    check("prst_ready", 64'(cfg_ready), 64'd1);
    model_reset();
    step();
    step();
    reset_n = 1'b1;
    sample_en = 1'b1;
    p0 = pulse_cnt;
    repeat (4) step();
    check("prst_no_apply", 64'(pulse_cnt - p0), 64'd0);
    check("prst_gen_hold", 64'(tap_gen), 64'd0);
    check("prst_taps_hold", 64'(|taps_active), 64'd0);
    sample_en = 1'b0;

    // Shadow was discarded by reset: a partial commit leaves tap 20 at zero
    send_beat(5, 32'h0000_1234, 1'b1);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    check("post_tap5", 64'(tap(5)), 64'h1234);
    check("post_tap20", 64'(tap(20)), 64'd0);
    check("post_gen", 64'(tap_gen), 64'd1);
    step();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_tap_cfg_ctrl.md
# fir_tap_cfg_ctrl

Configuration controller that turns the FIR filter's fixed coefficient set into a runtime-programmable one. A host writes coefficients one at a time into a shadow bank over a valid/ready port, then commits. The controller copies the shadow bank into the active bank that drives the filter's taps input, only on a sample boundary. The filter therefore never computes an output with a mix of old and new coefficients.

## Interface
- TAP_WIDTH, 32, coefficient width (signed).
- TAP_COUNT, 51, number of taps; ADDR_WIDTH = $clog2(TAP_COUNT) derived as localparam.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  host write beat valid.
- cfg_ready  out  1  controller can accept a beat.
- cfg_addr  in  ADDR_WIDTH  tap index.
- cfg_data  in  TAP_WIDTH  signed coefficient.
- cfg_commit  in  1  qualifies the beat as the last of an update; applies when the beat is accepted.
- sample_en  in  1  filter consumes a new input sample this cycle.
- taps_active  out  TAP_COUNT*TAP_WIDTH  flat active bank; tap i is at bits [i*TAP_WIDTH +: TAP_WIDTH].
- taps_update  out  1  one-cycle pulse; active bank changed at the preceding edge.
- tap_gen  out  8  count of applied commits, wraps 255->0.
- busy  out  1  commit pending (state PENDING).
- err_addr  out  1  sticky; an out-of-range address was received.

## Operation
- FSM states are IDLE, LOAD and PENDING.
  - IDLE -> LOAD on an accepted beat without commit.
  - IDLE/LOAD -> PENDING on an accepted beat with cfg_commit=1.
  - PENDING -> IDLE on a clock edge with sample_en=1.
- cfg_ready = 1 in IDLE/LOAD and 0 in PENDING. It is a registered function of state only and never depends on cfg_valid.
- Accepted beat = cfg_valid && cfg_ready at a rising edge.
  - If cfg_addr < TAP_COUNT: shadow[cfg_addr] <= cfg_data.
  - Otherwise: data is dropped, err_addr <= 1, and the beat's cfg_commit is still honoured.
- Shadow contents persist across commits, so partial updates (subset of taps) are legal.
- Apply happens at an edge in PENDING with sample_en=1:
  - active <= shadow (all taps in the same edge);
  - taps_update <= 1;
  - tap_gen <= tap_gen+1;
  - err_addr <= 0;
  - state <= IDLE.
- sample_en is ignored outside PENDING.
- Every output is 0 on reset, including taps_active, tap_gen, err_addr, busy and taps_update; state resets to IDLE. cfg_ready therefore resets to 1.
- Both banks reset to all-zero, so the filter outputs 0 until the first commit.
- Reset mid-LOAD or mid-PENDING discards shadow writes and the pending commit. No apply occurs.

## Timing
- Commit accepted at edge T: busy=1 and cfg_ready=0 from cycle T+1.
- sample_en=1 during the commit beat's own cycle does not apply. The earliest apply is at edge T+1, when sample_en=1 is sampled in PENDING.
- Apply at edge A:
  - taps_active holds the new values and taps_update=1 during cycle A+1;
  - busy=0 and cfg_ready=1 during cycle A+1;
  - taps_update returns to 0 at A+2 unless another apply occurs, which is impossible with a back-to-back minimum commit.
- Minimum spacing between applies is 2 cycles, because a new commit beat can be accepted at edge A+1.
- Write latency: a shadow write is visible at the edge after acceptance. A write and a commit on the same beat are both captured before any apply.
- An out-of-range beat sets err_addr at its acceptance edge. The error is visible until the apply edge, then clears.
- cfg_addr and cfg_data are don't-care when cfg_valid=0. Holding cfg_valid while cfg_ready=0 has no side effect.

## Structure
- Package fir_cfg_pkg holds:
  - the state enum typedef (IDLE, LOAD, PENDING);
  - default TAP_WIDTH and TAP_COUNT constants, shared with the filter datapath;
  - the tap_gen width constant (8).
- Sub-module fir_tap_bank holds the shadow/active register pair with a write port (we, addr, data) and an apply strobe. It is instantiated once. The FSM, handshake, error and generation logic stay in the top.

## Test plan
- Reset, then no stimulus -> cfg_ready=1, busy=0, taps_active all 0, tap_gen=0, err_addr=0.
- Write addr 0..50 with data i*3-25, commit on addr 50, sample_en=1 from 4 cycles later -> busy for 4 cycles, single taps_update pulse, tap 7 = -4, tap_gen=1.
- Partial update: write only addr 10 = 0x7FFFFFFF with commit -> after apply, tap 10 changes and all other taps keep their previous values.
- Beat with addr 60 and commit -> err_addr=1 at acceptance, no tap changes, err_addr=0 and tap_gen incremented after apply.
- Commit beat with sample_en held high continuously -> apply at the very next edge; taps_update high exactly one cycle; a new commit is accepted the following cycle; tap_gen increments twice in 2-cycle spacing.
- Assert reset_n low asynchronously while in PENDING -> taps_active, busy and tap_gen go to 0 immediately. After release, no apply occurs even with sample_en=1.
